// File: rtl/call_request_latch.sv
// Pending-request store for a 3-floor elevator: latches hall/car button presses until served.
// Optional input debounce (two consecutive high samples) is enabled by defining REQ_DEBOUNCE_EN.
module call_request_latch (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] raw_up,
  input  logic [2:0] raw_down,
  input  logic [2:0] raw_in,
  input  logic [1:0] floor_cur,
  input  logic [1:0] pos_cur,
  input  logic       open_cur,
  input  logic [1:0] dir_cur,
  output logic [2:0] req_up,
  output logic [2:0] req_down,
  output logic [2:0] req_in,
  output logic       req_any,
  output logic       req_above,
  output logic       req_below,
  output logic [2:0] req_count
);

  logic [2:0] req_up_q, req_up_d;
  logic [2:0] req_down_q, req_down_d;
  logic [2:0] req_in_q, req_in_d;
  logic [2:0] press_up, press_down, press_in;
  logic       svc;
  logic [2:0] floor_oh;
  logic [2:0] clr_up, clr_down, clr_in;
  logic [2:0] floor_any, above_mask, below_mask;

`ifdef REQ_DEBOUNCE_EN
  logic [2:0] samp_up_q, samp_up_d;
  logic [2:0] samp_down_q, samp_down_d;
  logic [2:0] samp_in_q, samp_in_d;

  always_comb begin
    samp_up_d   = raw_up;
    samp_down_d = raw_down;
    samp_in_d   = raw_in;
    // A press qualifies only when seen high on this edge and the previous one.
    press_up    = raw_up & samp_up_q;
    press_down  = raw_down & samp_down_q;
    press_in    = raw_in & samp_in_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      samp_up_q   <= 3'b000;
      samp_down_q <= 3'b000;
      samp_in_q   <= 3'b000;
    end else begin
      samp_up_q   <= samp_up_d;
      samp_down_q <= samp_down_d;
      samp_in_q   <= samp_in_d;
    end
  end
`else
  always_comb begin
    press_up   = raw_up;
    press_down = raw_down;
    press_in   = raw_in;
  end
`endif

  always_comb begin
    svc = (pos_cur == 2'b00) && open_cur && (floor_cur != 2'd3);
    floor_oh = 3'b000;
    if (svc) begin
      case (floor_cur)
        2'd0:    floor_oh = 3'b001;
        2'd1:    floor_oh = 3'b010;
        2'd2:    floor_oh = 3'b100;
        default: floor_oh = 3'b000;
      endcase
    end
    // Hall calls against the travel direction stay pending; idle or invalid direction clears both.
    clr_in   = floor_oh;
    clr_up   = (dir_cur != 2'b10) ? floor_oh : 3'b000;
    clr_down = (dir_cur != 2'b01) ? floor_oh : 3'b000;

    req_up_d   = (req_up_q | press_up) & ~clr_up & 3'b011;
    req_down_d = (req_down_q | press_down) & ~clr_down & 3'b110;
    req_in_d   = (req_in_q | press_in) & ~clr_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_up_q   <= 3'b000;
      req_down_q <= 3'b000;
      req_in_q   <= 3'b000;
    end else begin
      req_up_q   <= req_up_d;
      req_down_q <= req_down_d;
      req_in_q   <= req_in_d;
    end
  end

  always_comb begin
    floor_any = req_up_q | req_down_q | req_in_q;
    case (floor_cur)
      2'd0:    begin above_mask = 3'b110; below_mask = 3'b000; end
      2'd1:    begin above_mask = 3'b100; below_mask = 3'b001; end
      2'd2:    begin above_mask = 3'b000; below_mask = 3'b011; end
      default: begin above_mask = 3'b000; below_mask = 3'b000; end
    endcase
  end

  assign req_up    = req_up_q;
  assign req_down  = req_down_q;
  assign req_in    = req_in_q;
  assign req_any   = |floor_any;
  assign req_above = |(floor_any & above_mask);
  assign req_below = |(floor_any & below_mask);
  assign req_count = {2'b00, req_up_q[0]} + {2'b00, req_up_q[1]} +
                     {2'b00, req_down_q[1]} + {2'b00, req_down_q[2]} +
                     {2'b00, req_in_q[0]} + {2'b00, req_in_q[1]} + {2'b00, req_in_q[2]};

endmodule

// File: tb/tb_call_request_latch.sv
// Scoreboard bench for call_request_latch: directed scenarios then random traffic,
// checked against a per-floor/per-button reference model.
module tb_call_request_latch;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] raw_up, raw_down, raw_in;
  logic [1:0] floor_cur, pos_cur, dir_cur;
  logic       open_cur;
  logic [2:0] req_up, req_down, req_in, req_count;
  logic       req_any, req_above, req_below;

  call_request_latch dut (
    .clk(clk), .reset(reset),
    .raw_up(raw_up), .raw_down(raw_down), .raw_in(raw_in),
    .floor_cur(floor_cur), .pos_cur(pos_cur), .open_cur(open_cur), .dir_cur(dir_cur),
    .req_up(req_up), .req_down(req_down), .req_in(req_in),
    .req_any(req_any), .req_above(req_above), .req_below(req_below), .req_count(req_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] up, down, in_;
    logic       any, above, below;
    logic [2:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference state: pend[kind][floor], kind 0=up 1=down 2=in
  bit   pend[3][3];
  bit   samp[3][3];
  bit   model_valid = 0;

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model_outputs(input logic [1:0] floor);
    exp_t e;
    int   n;
    e = '0;
    n = 0;
    for (int f = 0; f < 3; f++) begin
      e.up[f]  = pend[0][f];
      e.down[f] = pend[1][f];
      e.in_[f] = pend[2][f];
      for (int k = 0; k < 3; k++) begin
        if (pend[k][f]) begin
          n++;
          if (floor != 2'd3 && f > int'(floor)) e.above = 1'b1;
          if (floor != 2'd3 && f < int'(floor)) e.below = 1'b1;
        end
      end
    end
    e.any = (n > 0);
    e.cnt = 3'(n);
    return e;
  endfunction

  task automatic model_update();
    bit raw, qual, serve, clr;
    if (reset) begin
      for (int k = 0; k < 3; k++)
        for (int f = 0; f < 3; f++) begin
          pend[k][f] = 0;
          samp[k][f] = 0;
        end
      model_valid = 1;
      return;
    end
    for (int k = 0; k < 3; k++) begin
      for (int f = 0; f < 3; f++) begin
        raw = (k == 0) ? raw_up[f] : (k == 1) ? raw_down[f] : raw_in[f];
`ifdef REQ_DEBOUNCE_EN
        qual = raw && samp[k][f];
`else
        qual = raw;
`endif
        serve = (pos_cur == 2'b00) && open_cur && (floor_cur != 2'd3) && (int'(floor_cur) == f);
        if (k == 0)      clr = serve && (dir_cur != 2'b10);
        else if (k == 1) clr = serve && (dir_cur != 2'b01);
        else             clr = serve;
        if (clr)       pend[k][f] = 0;
        else if (qual) pend[k][f] = 1;
        if ((k == 0 && f == 2) || (k == 1 && f == 0)) pend[k][f] = 0;
        samp[k][f] = raw;
      end
    end
  endtask

  // One clock cycle of stimulus; expected outputs for this cycle go to the scoreboard.
  task automatic step(input logic rst, input logic [2:0] up, input logic [2:0] dn,
                      input logic [2:0] in_, input logic [1:0] fl, input logic [1:0] pos,
                      input logic opn, input logic [1:0] dir);
    @(posedge clk);
    #1;
    reset = rst; raw_up = up; raw_down = dn; raw_in = in_;
    floor_cur = fl; pos_cur = pos; open_cur = opn; dir_cur = dir;
    if (model_valid) exp_q.push_back(model_outputs(fl));
    model_update();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("req_up", req_up, e.up);
        chk("req_down", req_down, e.down);
        chk("req_in", req_in, e.in_);
        chk("req_any", {2'b00, req_any}, {2'b00, e.any});
        chk("req_above", {2'b00, req_above}, {2'b00, e.above});
        chk("req_below", {2'b00, req_below}, {2'b00, e.below});
        chk("req_count", req_count, e.cnt);
      end
    end
  end

  initial begin : stim
    logic [2:0] u, d, c;
    reset = 1'b1; raw_up = '0; raw_down = '0; raw_in = '0;
    floor_cur = '0; pos_cur = '0; open_cur = 1'b0; dir_cur = '0;

    // Reset with every button pressed, then release
    repeat (2) step(1, 3'b111, 3'b111, 3'b111, 2'd0, 2'b00, 0, 2'b00);
    repeat (3) step(0, 3'b000, 3'b000, 3'b000, 2'd0, 2'b01, 0, 2'b00);

    // Latch and hold a car call above
    step(0, 3'b000, 3'b000, 3'b100, 2'd0, 2'b00, 0, 2'b00);
    step(0, 3'b000, 3'b000, 3'b100, 2'd0, 2'b00, 0, 2'b00);
    repeat (20) step(0, 3'b000, 3'b000, 3'b000, 2'd0, 2'b00, 0, 2'b00);

    // Directional clear at floor 1, going up then idle
    repeat (2) step(0, 3'b010, 3'b010, 3'b000, 2'd0, 2'b00, 0, 2'b00);
    step(0, 3'b000, 3'b000, 3'b000, 2'd1, 2'b00, 1, 2'b01);
    repeat (2) step(0, 3'b000, 3'b000, 3'b000, 2'd1, 2'b00, 0, 2'b01);
    repeat (2) step(0, 3'b010, 3'b010, 3'b000, 2'd0, 2'b00, 0, 2'b00);
    step(0, 3'b000, 3'b000, 3'b000, 2'd1, 2'b00, 1, 2'b00);
    repeat (2) step(0, 3'b000, 3'b000, 3'b000, 2'd1, 2'b00, 0, 2'b00);

    // Set/clear collision while serving floor 0, then close the door
    repeat (4) step(0, 3'b000, 3'b000, 3'b001, 2'd0, 2'b00, 1, 2'b00);
    repeat (3) step(0, 3'b000, 3'b000, 3'b001, 2'd0, 2'b00, 0, 2'b00);
    step(0, 3'b000, 3'b000, 3'b000, 2'd0, 2'b00, 0, 2'b00);

    // Invalid floor with the door open
    repeat (2) step(0, 3'b011, 3'b110, 3'b111, 2'd1, 2'b10, 0, 2'b10);
    repeat (4) step(0, 3'b000, 3'b000, 3'b000, 2'd3, 2'b00, 1, 2'b00);
    step(0, 3'b000, 3'b000, 3'b000, 2'd2, 2'b00, 0, 2'b00);

    // Reset mid-operation, then single- and two-cycle pulses on raw_up[0]
    step(1, 3'b001, 3'b000, 3'b000, 2'd2, 2'b00, 0, 2'b00);
    repeat (2) step(0, 3'b000, 3'b000, 3'b000, 2'd2, 2'b00, 0, 2'b00);
    step(0, 3'b001, 3'b000, 3'b000, 2'd2, 2'b00, 0, 2'b00);
    repeat (3) step(0, 3'b000, 3'b000, 3'b000, 2'd2, 2'b00, 0, 2'b00);
    repeat (2) step(0, 3'b001, 3'b000, 3'b000, 2'd2, 2'b00, 0, 2'b00);
    repeat (3) step(0, 3'b000, 3'b000, 3'b000, 2'd2, 2'b00, 0, 2'b00);

    // Random traffic; buttons often held so debounced builds still latch
    u = '0; d = '0; c = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        u = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
        d = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
        c = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
      end
      step(($urandom_range(0, 199) == 0), u, d, c,
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)));
    end
    step(0, 3'b000, 3'b000, 3'b000, 2'd0, 2'b00, 0, 2'b00);

    repeat (5) begin
      if (exp_q.size() != 0) @(negedge clk);
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0 pending entries", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/call_request_latch.md
# call_request_latch

Registered request store for the 3-floor elevator. It captures momentary hall-call and car-call button pulses and holds each one as a pending request. A request is cleared when the car serves it: the car is stopped at that floor with the door open. The held vectors feed the per-state next-state controllers as their `button_up`/`button_down`/`button_in` inputs. The block also reports summary flags for direction decisions.

## Interface
Parameters:
- none (floor count fixed at 3)

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `raw_up`  in  3  hall up-call buttons, bit f = floor f; bit 2 has no physical button
- `raw_down`  in  3  hall down-call buttons; bit 0 has no physical button
- `raw_in`  in  3  car-panel floor buttons
- `floor_cur`  in  2  current car floor, binary 0..2; 3 is invalid
- `pos_cur`  in  2  position register: 00 = at floor, 01 = half-way up, 10 = half-way down
- `open_cur`  in  1  door-open register
- `dir_cur`  in  2  direction register: 00 idle, 01 up, 10 down
- `req_up`  out  3  latched up-call requests
- `req_down`  out  3  latched down-call requests
- `req_in`  out  3  latched car-call requests
- `req_any`  out  1  any latched request
- `req_above`  out  1  any request at a floor > `floor_cur`
- `req_below`  out  1  any request at a floor < `floor_cur`
- `req_count`  out  3  number of set request bits, 0..7

## Operation
- **Reset:** all request registers and all outputs are 0; the debounce stage (if present) is 0.
- **Latch:** a qualified press on bit f sets the corresponding `req_*[f]`. The bit stays set until it is cleared; further presses while set have no effect.
- **Non-physical bits:** `req_up[2]` and `req_down[0]` are forced to 0 regardless of the raw inputs.
- **Service condition:** `pos_cur==00 && open_cur==1 && floor_cur!=3`. Let f = `floor_cur`. When the condition holds:
  - `req_in[f]` clears.
  - `req_up[f]` clears if `dir_cur!=10`.
  - `req_down[f]` clears if `dir_cur!=01`.
- **Simultaneous set and clear on the same bit:** clear wins. A press at the floor being served with the door open counts as satisfied.
- **Simultaneous events on different bits:** independent.
- **Invalid `floor_cur==3`:**
  - No clears occur.
  - `req_above` and `req_below` are 0.
  - Latching continues.
- **Invalid `dir_cur==11`:** treated as idle for the clear rule, so all three bits at f clear.
- **Summary outputs:** `req_any`, `req_above`, `req_below` and `req_count` are combinational from the request registers and `floor_cur`. `req_count` is a 3-bit popcount of the 7 physical bits (max 7, no overflow).

## Timing
- **Press latency, no debounce:** a raw bit high during the cycle before edge n makes `req_*` high after edge n (1 cycle).
- **Clear latency:** service condition true before edge n means the bit is 0 after edge n.
- **Summary outputs:** same cycle as the request registers they derive from.
- **Reset:** takes effect at the edge where `reset` is sampled high. It overrides any press or clear in that cycle.
- **Reset mid-operation:** all pending requests are lost, with no partial state. The next press is treated as new.
- **Held buttons:** a button held high across a service cycle re-latches on the first edge after the service condition drops.

## Configuration
- **`REQ_DEBOUNCE_EN` defined:**
  - Each raw bit passes through a 1-deep sample register.
  - A press qualifies only when the raw bit is high on two consecutive edges.
  - Press latency becomes 2 cycles; a single-cycle glitch is never latched.
  - The sample register clears on reset.
- **`REQ_DEBOUNCE_EN` undefined:** any raw high sampled on an edge qualifies, with 1-cycle latency and no sample register.
- Clear behaviour and summary outputs are identical in both builds.

## Test plan
- **Reset:** assert `reset` with all raw inputs = 111 → every output is 0 after the edge; `req_up[2]` and `req_down[0]` stay 0 after release.
- **Latch and hold:** pulse `raw_in[2]` for one cycle with `floor_cur`=0, door closed → `req_in`=100, `req_above`=1, `req_count`=1. Values hold for 20 cycles.
- **Directional clear:** set `req_up[1]` and `req_down[1]`; then `floor_cur`=1, `pos_cur`=00, `open_cur`=1, `dir_cur`=01 → after 1 edge `req_up`=000 and `req_down`=010. Repeat with `dir_cur`=00 → both clear.
- **Set/clear collision:** with the door open at floor 0 and idle, hold `raw_in[0]` → `req_in[0]` stays 0. Close the door → `req_in[0]`=1 on the next edge.
- **Invalid floor:** `floor_cur`=3 with the door open and requests pending → nothing clears; `req_above` and `req_below` are 0.
- **Debounce, `REQ_DEBOUNCE_EN` build only:** a 1-cycle `raw_up[0]` pulse → not latched. A 2-cycle pulse → `req_up[0]`=1 exactly 2 edges after the rise.
